fmul_norm_round: RTL and testbench

//  Final stage of the pipelined single-precision multiplier. Consumes the carry-propagated product z[47:8] from the

---
 rtl/fpu_pkg.sv | 16 +
 rtl/fmul_round.sv | 31 +++
 rtl/fmul_norm_round.sv | 106 ++++++++++
 tb/tb_fmul_norm_round.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU rounding-mode codes, IEEE-754 single constants and exception flag bit positions
package fpu_pkg;
  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RDN = 2'b01,
    RM_RUP = 2'b10,
    RM_RZ  = 2'b11
  } rm_e;
  localparam logic [31:0] NAN_DEFAULT = 32'h7fc00000;
  localparam logic [31:0] INF         = 32'h7f800000;
  localparam logic [31:0] FLT_MAX     = 32'h7f7fffff;
  localparam int FL_NV = 3;
  localparam int FL_OF = 2;
  localparam int FL_UF = 1;
  localparam int FL_NX = 0;
endpackage

// File: rtl/fmul_round.sv
// fmul_round: combinational rounder; {m,g,st,sign,rm,e} in, {frac,exp,overflow,inexact} out (m has hidden bit at [23])
module fmul_round
  import fpu_pkg::*;
(
  input  logic [23:0] m,
  input  logic        g,
  input  logic        st,
  input  logic        sign,
  input  logic [1:0]  rm,
  input  logic [9:0]  e,
  output logic [22:0] frac,
  output logic [7:0]  exp,
  output logic        overflow,
  output logic        inexact
);
  logic        inc;
  logic [24:0] sum;
  logic [10:0] e_r;
  always_comb begin
    inexact  = g | st;
    inc      = rm == RM_RNE ? g & (st | m[0]) :
               rm == RM_RDN ? sign & inexact :
               rm == RM_RUP ? ~sign & inexact : 1'b0;
    sum      = {1'b0, m} + {24'd0, inc};
    // a clear hidden bit after rounding means the carry reached bit 24: mantissa becomes 1.0
    frac     = sum[23] ? sum[22:0] : 23'd0;
    e_r      = {e[9], e} + {10'd0, sum[24]};
    exp      = e_r[7:0];
    overflow = ~e_r[10] & (e_r[9:0] >= 10'd255);
  end
endmodule

// File: rtl/fmul_norm_round.sv
// fmul_norm_round: 2-stage normalise/round/pack of a single-precision product with valid/ready back-pressure
//   in:  clk, rst, in_valid, z[39:0], z_lo_nz, sign, exp_in[9:0], is_nan, is_inf, is_zero, rm[1:0], out_ready
//   out: in_ready, out_valid, s[31:0]
//   FMUL_NR_FLAGS_EN adds in_nv, flags_clr (in) and sticky flags[3:0] = {nv,of,uf,nx} (out)
module fmul_norm_round
  import fpu_pkg::*;
#(
  parameter logic [31:0] NAN_VALUE = NAN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [39:0] z,
  input  logic        z_lo_nz,
  input  logic        sign,
  input  logic [9:0]  exp_in,
  input  logic        is_nan,
  input  logic        is_inf,
  input  logic        is_zero,
  input  logic [1:0]  rm,
`ifdef FMUL_NR_FLAGS_EN
  input  logic        in_nv,
  input  logic        flags_clr,
  output logic [3:0]  flags,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] s
);
  logic        v1, v2, adv1, adv2;
  logic [23:0] m_n, m1;
  logic        g_n, st_n, g1, st1, sign1, nan1, inf1, zero1;
  logic [9:0]  e_n, e1;
  logic [1:0]  rm1;
  logic [22:0] frac;
  logic [7:0]  exp_r;
  logic        ovf, inexact, flush, ovf_inf;
  logic [31:0] s_n;
  assign adv2      = ~v2 | out_ready;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;
  always_comb begin
    m_n  = z[39] ? z[39:16] : z[38:15];
    g_n  = z[39] ? z[15] : z[14];
    st_n = (z[39] ? |z[14:0] : |z[13:0]) | z_lo_nz;
    e_n  = z[39] ? exp_in + 10'd1 : exp_in;
  end
  always_ff @(posedge clk)
    if (adv1 & in_valid) begin
      m1    <= m_n;
      g1    <= g_n;
      st1   <= st_n;
      e1    <= e_n;
      sign1 <= sign;
      rm1   <= rm;
      nan1  <= is_nan;
      inf1  <= is_inf;
      zero1 <= is_zero;
    end
  fmul_round u_round (
    .m(m1), .g(g1), .st(st1), .sign(sign1), .rm(rm1), .e(e1),
    .frac(frac), .exp(exp_r), .overflow(ovf), .inexact(inexact)
  );
  always_comb begin
    flush   = e1[9] | (e1 == 10'd0);
    ovf_inf = rm1 == RM_RNE | (rm1 == RM_RUP & ~sign1) | (rm1 == RM_RDN & sign1);
    s_n     = nan1  ? NAN_VALUE :
              inf1  ? {sign1, INF[30:0]} :
              zero1 | flush ? {sign1, 31'd0} :
              ovf   ? {sign1, ovf_inf ? INF[30:0] : FLT_MAX[30:0]} :
                      {sign1, exp_r, frac};
  end
  always_ff @(posedge clk)
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      s  <= 32'd0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
      if (adv2 & v1) s <= s_n;
    end
`ifdef FMUL_NR_FLAGS_EN
  logic       nv1;
  logic [3:0] fl_n, fl2;
  always_ff @(posedge clk)
    if (adv1 & in_valid) nv1 <= in_nv;
  always_comb begin
    fl_n        = 4'd0;
    fl_n[FL_NV] = nv1;
    fl_n[FL_OF] = ~(nan1 | inf1 | zero1) & ~flush & ovf;
    fl_n[FL_UF] = ~(nan1 | inf1 | zero1) & flush;
    fl_n[FL_NX] = ~(nan1 | inf1 | zero1) & inexact;
  end
  always_ff @(posedge clk)
    if (adv2 & v1) fl2 <= fl_n;
  always_ff @(posedge clk)
    if (rst) flags <= 4'd0;
    else flags <= (flags_clr ? 4'd0 : flags) | (v2 & out_ready ? fl2 : 4'd0);
`else
  logic unused_nx;
  assign unused_nx = inexact;
`endif
endmodule

// File: tb/tb_fmul_norm_round.sv
// tb_fmul_norm_round: directed and randomized checks of fmul_norm_round against an arithmetic reference model
module tb_fmul_norm_round;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [39:0] z = '0;
  logic        z_lo_nz = 1'b0, sign = 1'b0;
  logic [9:0]  exp_in = '0;
  logic        is_nan = 1'b0, is_inf = 1'b0, is_zero = 1'b0;
  logic [1:0]  rm = 2'b00;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] s;
`ifdef FMUL_NR_FLAGS_EN
  logic        in_nv = 1'b0, flags_clr = 1'b0;
  logic [3:0]  flags;
`endif
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic        held = 1'b0;
  logic [31:0] held_s;

  typedef struct {
    logic [39:0] z;
    logic        lo, sign, nan, inf, zero;
    logic [9:0]  e;
    logic [1:0]  rm;
  } txn_t;

  fmul_norm_round dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .z(z), .z_lo_nz(z_lo_nz),
    .sign(sign), .exp_in(exp_in), .is_nan(is_nan), .is_inf(is_inf), .is_zero(is_zero), .rm(rm),
`ifdef FMUL_NR_FLAGS_EN
    .in_nv(in_nv), .flags_clr(flags_clr), .flags(flags),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .s(s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // value-level reference: pick the 24 leading bits, classify the discarded remainder against one half ulp
  function automatic logic [31:0] model(input txn_t t);
    int sh, e;
    longint unsigned m, rem, half;
    bit gt, tie, nx, inc;
    if (t.nan) return 32'h7fc00000;
    if (t.inf) return {t.sign, 31'h7f800000};
    if (t.zero) return {t.sign, 31'd0};
    sh   = t.z[39] ? 16 : 15;
    m    = longint'(t.z) >> sh;
    rem  = longint'(t.z) & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    e    = int'($signed(t.e)) + (t.z[39] ? 1 : 0);
    if (e <= 0) return {t.sign, 31'd0};
    gt  = rem > half || (rem == half && t.lo);
    tie = rem == half && !t.lo;
    nx  = rem != 0 || t.lo;
    case (t.rm)
      2'd0: inc = gt || (tie && m[0]);
      2'd1: inc = t.sign && nx;
      2'd2: inc = !t.sign && nx;
      default: inc = 1'b0;
    endcase
    m = m + longint'(inc);
    if (m == (64'd1 << 24)) begin
      m = 64'd1 << 23;
      e++;
    end
    if (e >= 255)
      return (t.rm == 2'd0 || (t.rm == 2'd2 && !t.sign) || (t.rm == 2'd1 && t.sign)) ?
             {t.sign, 31'h7f800000} : {t.sign, 31'h7f7fffff};
    return {t.sign, e[7:0], m[22:0]};
  endfunction

  function automatic txn_t mk(input logic [39:0] zz, input logic sg, input logic [9:0] e, input logic [1:0] r);
    txn_t t;
    t.z = zz; t.lo = 1'b0; t.sign = sg; t.e = e; t.rm = r;
    t.nan = 1'b0; t.inf = 1'b0; t.zero = 1'b0;
    return t;
  endfunction

  function automatic txn_t rnd();
    txn_t t;
    t.z = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 1) t.z[39] = 1'b1;
    else t.z[39:38] = 2'b01;
    if ($urandom_range(0, 3) == 0) t.z[14:0] = {1'b1, 14'd0};
    t.lo   = $urandom_range(0, 3) == 0;
    t.sign = $urandom_range(0, 1) == 1;
    t.e    = 10'($urandom_range(0, 310)) - 10'd20;
    t.rm   = 2'($urandom_range(0, 3));
    t.nan  = $urandom_range(0, 15) == 0;
    t.inf  = $urandom_range(0, 15) == 0;
    t.zero = $urandom_range(0, 15) == 0;
    return t;
  endfunction

  // one cycle: drive at negedge, then score output transfer, hold stability and input acceptance
  task automatic cyc(input logic iv, input txn_t t, input logic ordy);
    @(negedge clk);
    rst = 1'b0; in_valid = iv; out_ready = ordy;
    z = t.z; z_lo_nz = t.lo; sign = t.sign; exp_in = t.e; rm = t.rm;
    is_nan = t.nan; is_inf = t.inf; is_zero = t.zero;
    #1;
    if (held) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_s", s, held_s);
    end
    if (out_valid && out_ready) begin
      chk("result", s, q.size() > 0 ? q[0] : 32'hxxxxxxxx);
      if (q.size() > 0) void'(q.pop_front());
    end
    held   = out_valid & ~out_ready;
    held_s = s;
    if (iv && in_ready) q.push_back(model(t));
  endtask

  task automatic directed(input txn_t t, input logic [31:0] expv, input string tag);
    txn_t idle;
    idle = mk(40'd0, 1'b0, 10'd0, 2'd0);
    cyc(1'b1, t, 1'b1);
    cyc(1'b0, idle, 1'b1);
    chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    cyc(1'b0, idle, 1'b1);
    chk({tag, "_lat2"}, {31'd0, out_valid}, 32'd1);
    chk(tag, s, expv);
  endtask

  task automatic drain();
    txn_t idle;
    idle = mk(40'd0, 1'b0, 10'd0, 2'd0);
    for (int i = 0; i < 20 && q.size() > 0; i++) cyc(1'b0, idle, 1'b1);
    cyc(1'b0, idle, 1'b1);
    chk("drain_empty", q.size(), 32'd0);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    txn_t t, idle;
    idle = mk(40'd0, 1'b0, 10'd0, 2'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_s", s, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    directed(mk(40'h9000000000, 1'b0, 10'd127, 2'd0), 32'h40100000, "mul_1p5");
    directed(mk(40'h4000004000, 1'b0, 10'd127, 2'd0), 32'h3f800000, "rne_tie_even");
    directed(mk(40'h400000c000, 1'b0, 10'd127, 2'd0), 32'h3f800002, "rne_tie_odd");
    directed(mk(40'h7fffffc000, 1'b0, 10'd127, 2'd0), 32'h40000000, "rne_carry");
    directed(mk(40'h9000000000, 1'b0, 10'd254, 2'd0), 32'h7f800000, "ovf_rne");
    directed(mk(40'h9000000000, 1'b0, 10'd254, 2'd3), 32'h7f7fffff, "ovf_rz");
    directed(mk(40'h9000000000, 1'b0, 10'd254, 2'd1), 32'h7f7fffff, "ovf_rdn_pos");
    directed(mk(40'h9000000000, 1'b1, 10'd254, 2'd1), 32'hff800000, "ovf_rdn_neg");
    directed(mk(40'h4000000000, 1'b1, 10'd0, 2'd0), 32'h80000000, "flush_neg");
    t = mk(40'h1234567890 | 40'h8000000000, 1'b0, 10'd100, 2'd2);
    t.nan = 1'b1;
    directed(t, 32'h7fc00000, "nan");
    t = mk(40'h9000000000, 1'b1, 10'd100, 2'd0);
    t.inf = 1'b1;
    directed(t, 32'hff800000, "inf_neg");

    // back-pressure: two held in the pipe, third refused while out_ready is low
    cyc(1'b1, mk(40'h9000000000, 1'b0, 10'd127, 2'd0), 1'b0);
    cyc(1'b1, mk(40'hc000000000, 1'b0, 10'd127, 2'd0), 1'b0);
    t = mk(40'h5000000000, 1'b1, 10'd130, 2'd0);
    cyc(1'b1, t, 1'b0);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_s_first", s, 32'h40100000);
    cyc(1'b1, t, 1'b1);
    cyc(1'b1, mk(40'h8000000000, 1'b1, 10'd1, 2'd3), 1'b1);
    drain();

    // reset with both stages full: nothing stale may come out afterwards
    cyc(1'b1, mk(40'h9000000000, 1'b0, 10'd127, 2'd0), 1'b0);
    cyc(1'b1, mk(40'hc000000000, 1'b0, 10'd127, 2'd0), 1'b0);
    @(negedge clk);
    #1;
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    held = 1'b0;
    repeat (4) cyc(1'b0, idle, 1'b1);

    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 9) < 7, rnd(), $urandom_range(0, 9) < 7);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
